// File: rtl/data_mem_responder_if.sv
// Load/store request and response signals between the MEM stage and the data memory.
interface data_mem_responder_if #(
    parameter int unsigned WORD_LEN = 32
);
    logic                MEM_R_EN;
    logic                MEM_W_EN;
    logic [WORD_LEN-1:0] address;
    logic [WORD_LEN-1:0] writeData;
    logic [WORD_LEN-1:0] readData;
    logic                ready;
    logic                err;

    // MEM stage side: issues requests, sees completion.
    modport master (
        output MEM_R_EN, MEM_W_EN, address, writeData,
        input  readData, ready, err
    );

    // Memory side: accepts requests, reports completion.
    modport slave (
        input  MEM_R_EN, MEM_W_EN, address, writeData,
        output readData, ready, err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Word-addressed data memory with a fixed number of wait states per access.
// ready drops while an access is in flight so the core can freeze around it.
module data_mem_responder #(
    parameter int unsigned WORD_LEN    = 32,
    parameter int unsigned DEPTH_LOG2  = 6,
    parameter int unsigned BASE_ADDR   = 1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic                  op_write_q;
    logic                  illegal_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [WORD_LEN-1:0]   wdata_q;
    logic [WORD_LEN-1:0]   read_hold;
    logic [WORD_LEN-1:0]   mem [DEPTH];

    logic                  req;
    logic [WORD_LEN-1:0]   offset;
    logic                  below_base;
    logic                  beyond_top;
    logic                  misaligned;
    logic                  illegal;
    logic [DEPTH_LOG2-1:0] idx;
    logic [WORD_LEN-1:0]   rd_word;

    // Decode the incoming request; both enables together is treated as an illegal store.
    assign req        = bus.MEM_R_EN | bus.MEM_W_EN;
    assign offset     = bus.address - WORD_LEN'(BASE_ADDR);
    assign below_base = bus.address < WORD_LEN'(BASE_ADDR);
    assign beyond_top = (offset >> (DEPTH_LOG2 + 2)) != '0;
    assign misaligned = bus.address[1:0] != 2'b00;
    assign illegal    = below_base | beyond_top | misaligned | (bus.MEM_R_EN & bus.MEM_W_EN);
    assign idx        = offset[DEPTH_LOG2+1:2];

    // Word seen by a completing load; illegal loads return zero.
    assign rd_word = illegal_q ? '0 : mem[idx_q];

    // Access sequencer: latch request in IDLE, count wait states, commit in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            op_write_q <= 1'b0;
            illegal_q  <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            read_hold  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_write_q <= bus.MEM_W_EN;
                        illegal_q  <= illegal;
                        idx_q      <= idx;
                        wdata_q    <= bus.writeData;
                        cnt        <= CNT_W'(WAIT_CYCLES);
                        state      <= (WAIT_CYCLES == 0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (op_write_q && !illegal_q) begin
                        mem[idx_q] <= wdata_q;
                    end
                    if (!op_write_q) begin
                        read_hold <= rd_word;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Completion and stall signalling; load data is live in DONE, otherwise the last load result.
    assign bus.ready    = (state == DONE) || ((state == IDLE) && !req);
    assign bus.err      = (state == DONE) && illegal_q;
    assign bus.readData = ((state == DONE) && !op_write_q) ? rd_word : read_hold;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed vector table, hand sequences and
// randomized accesses against an array-based reference model.
module tb_data_mem_responder;
    localparam int unsigned BASE = 1024;
    localparam int unsigned NW   = 64;

    logic clk;
    logic rst0;
    logic rst3;

    data_mem_responder_if #(.WORD_LEN(32)) bus0 ();
    data_mem_responder_if #(.WORD_LEN(32)) bus3 ();

    data_mem_responder #(
        .WORD_LEN(32), .DEPTH_LOG2(6), .BASE_ADDR(1024), .WAIT_CYCLES(0)
    ) dut0 (
        .clk(clk), .rst(rst0), .bus(bus0)
    );

    data_mem_responder #(
        .WORD_LEN(32), .DEPTH_LOG2(6), .BASE_ADDR(1024), .WAIT_CYCLES(3)
    ) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: one word array and one load-result register per instance (0: wait 0, 1: wait 3).
    logic [31:0] mdl_mem  [2][NW];
    logic [31:0] mdl_hold [2];

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
        if (sel == 0) begin
            bus0.MEM_R_EN = r; bus0.MEM_W_EN = w; bus0.address = a; bus0.writeData = d;
        end else begin
            bus3.MEM_R_EN = r; bus3.MEM_W_EN = w; bus3.address = a; bus3.writeData = d;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? bus0.ready : bus3.ready;
    endfunction

    function automatic logic get_err(input int sel);
        return (sel == 0) ? bus0.err : bus3.err;
    endfunction

    function automatic logic [31:0] get_rd(input int sel);
        return (sel == 0) ? bus0.readData : bus3.readData;
    endfunction

    // Starts at a negedge with the DUT idle; ends at the negedge of the following idle cycle.
    task automatic access(input int sel, input logic r, input logic w,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic exp_err, input logic [31:0] exp_rd, input string tag);
        int waits;
        waits = (sel == 0) ? 0 : 3;
        drive(sel, r, w, a, d);
        #1;
        check($sformatf("%s_stall0", tag), 32'(get_ready(sel)), 32'd0);
        for (int k = 1; k <= waits; k++) begin
            @(negedge clk);
            check($sformatf("%s_stall%0d", tag, k), 32'(get_ready(sel)), 32'd0);
        end
        @(negedge clk);
        check($sformatf("%s_done_ready", tag), 32'(get_ready(sel)), 32'd1);
        check($sformatf("%s_done_err", tag), 32'(get_err(sel)), 32'(exp_err));
        check($sformatf("%s_done_rd", tag), get_rd(sel), exp_rd);
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
    endtask

    task automatic check_idle(input int sel, input int cycles, input string tag);
        for (int k = 0; k < cycles; k++) begin
            check($sformatf("%s_ready%0d", tag, k), 32'(get_ready(sel)), 32'd1);
            check($sformatf("%s_err%0d", tag, k), 32'(get_err(sel)), 32'd0);
            check($sformatf("%s_rd%0d", tag, k), get_rd(sel), mdl_hold[sel]);
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int sel);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'd0, 32'd0);
        if (sel == 0) rst0 = 1'b1; else rst3 = 1'b1;
        repeat (2) @(negedge clk);
        if (sel == 0) rst0 = 1'b0; else rst3 = 1'b0;
        mdl_hold[sel] = 32'd0;
        for (int i = 0; i < NW; i++) mdl_mem[sel][i] = 32'd0;
        @(negedge clk);
    endtask

    // Model-driven access: expectations come from the address rules applied to the model array.
    task automatic model_access(input int sel, input logic r, input logic w,
                                input logic [31:0] a, input logic [31:0] d, input string tag);
        logic        legal;
        int unsigned word;
        logic [31:0] exp_rd;
        legal = (a >= BASE) && (a < BASE + 4 * NW) && (a % 4 == 0) && !(r && w);
        word  = legal ? (a - BASE) / 4 : 0;
        if (w) begin
            exp_rd = mdl_hold[sel];
            if (legal) mdl_mem[sel][word] = d;
        end else begin
            exp_rd        = legal ? mdl_mem[sel][word] : 32'd0;
            mdl_hold[sel] = exp_rd;
        end
        access(sel, r, w, a, d, !legal, exp_rd, tag);
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned kind;
        kind = $urandom_range(0, 5);
        case (kind)
            0:       return 32'(BASE + $urandom_range(0, 255));
            1:       return 32'(BASE - 4 * $urandom_range(1, 8));
            2:       return 32'(BASE + 256 + 4 * $urandom_range(0, 8));
            default: return 32'(BASE + 4 * $urandom_range(0, 63));
        endcase
    endfunction

    task automatic rand_run(input int sel, input int n);
        int unsigned kind;
        for (int i = 0; i < n; i++) begin
            kind = $urandom_range(0, 7);
            if (kind <= 2)
                model_access(sel, 1'b1, 1'b0, rand_addr(), $urandom, $sformatf("rnd%0d_%0d_rd", sel, i));
            else if (kind <= 5)
                model_access(sel, 1'b0, 1'b1, rand_addr(), $urandom, $sformatf("rnd%0d_%0d_wr", sel, i));
            else if (kind == 6)
                model_access(sel, 1'b1, 1'b1, rand_addr(), $urandom, $sformatf("rnd%0d_%0d_both", sel, i));
            else
                check_idle(sel, int'($urandom_range(1, 3)), $sformatf("rnd%0d_%0d_idle", sel, i));
        end
    endtask

    initial begin
        rst0 = 1'b1;
        rst3 = 1'b1;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int s = 0; s < 2; s++) begin
            mdl_hold[s] = 32'd0;
            for (int i = 0; i < NW; i++) mdl_mem[s][i] = 32'd0;
        end
        repeat (3) @(negedge clk);
        rst0 = 1'b0;
        rst3 = 1'b0;
        @(negedge clk);

        // Reset state of both instances.
        check("rst_ready0", 32'(bus0.ready), 32'd1);
        check("rst_err0", 32'(bus0.err), 32'd0);
        check("rst_rd0", bus0.readData, 32'd0);
        check("rst_ready3", 32'(bus3.ready), 32'd1);
        check("rst_err3", 32'(bus3.err), 32'd0);
        check("rst_rd3", bus3.readData, 32'd0);

        // Directed vectors on the 3-wait-state instance.
        tbl[0]  = '{1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 32'd1028, 32'h0,        1'b0, 32'hDEADBEEF};
        tbl[2]  = '{1'b0, 1'b1, 32'd1280, 32'h12345678, 1'b1, 32'hDEADBEEF};
        tbl[3]  = '{1'b1, 1'b0, 32'd1030, 32'h0,        1'b1, 32'h0};
        tbl[4]  = '{1'b1, 1'b0, 32'd1024, 32'h0,        1'b0, 32'h0};
        tbl[5]  = '{1'b1, 1'b1, 32'd1040, 32'h1,        1'b1, 32'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'd1040, 32'h0,        1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b1, 32'd1276, 32'h55AA55AA, 1'b0, 32'h0};
        tbl[8]  = '{1'b1, 1'b0, 32'd1276, 32'h0,        1'b0, 32'h55AA55AA};
        tbl[9]  = '{1'b1, 1'b0, 32'd1020, 32'h0,        1'b1, 32'h0};
        tbl[10] = '{1'b1, 1'b0, 32'd1028, 32'h0,        1'b0, 32'hDEADBEEF};
        for (int i = 0; i < 11; i++) begin
            access(1, tbl[i].r, tbl[i].w, tbl[i].addr, tbl[i].wdata,
                   tbl[i].exp_err, tbl[i].exp_rd, $sformatf("vec%0d", i));
        end

        // Ten idle cycles: ready stays high and the last load result is held.
        mdl_hold[1] = 32'hDEADBEEF;
        check_idle(1, 10, "idle");

        // Reset in the second BUSY cycle drops the store.
        drive(1, 1'b0, 1'b1, 32'd1036, 32'hCAFEF00D);
        #1;
        check("mid_rst_stall", 32'(bus3.ready), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b1;
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        @(negedge clk);
        check("mid_rst_ready", 32'(bus3.ready), 32'd1);
        check("mid_rst_err", 32'(bus3.err), 32'd0);
        check("mid_rst_rd", bus3.readData, 32'd0);
        rst3 = 1'b0;
        @(negedge clk);
        access(1, 1'b1, 1'b0, 32'd1036, 32'd0, 1'b0, 32'd0, "mid_rst_load");
        access(1, 1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 32'd0, "rst_cleared");

        // Zero wait states: store then load in the idle cycle right after DONE.
        access(0, 1'b0, 1'b1, 32'd1032, 32'hA5A5A5A5, 1'b0, 32'd0, "w0_store");
        access(0, 1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 32'hA5A5A5A5, "w0_load");

        // Randomized traffic against the reference model on both instances.
        do_reset(1);
        rand_run(1, 60);
        do_reset(0);
        rand_run(0, 60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
